// File: rtl/qwac_pkg.sv
// Shared constants and saturation helper for the vector accumulate stream.
package qwac_pkg;

  localparam int QWAC_ACC_BITS = 32;

  typedef struct packed {
    logic signed [63:0] val;
    logic               clip;
  } sat_t;

  function automatic sat_t sat_clip(input logic signed [63:0] value,
                                    input int unsigned        width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sat_t               r;
    hi     = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo     = -hi - 64'sd1;
    r.clip = 1'b1;
    if (value > hi) begin
      r.val = hi;
    end else if (value < lo) begin
      r.val = lo;
    end else begin
      r.val  = value;
      r.clip = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/vec_tree_sum.sv
// Combinational balanced signed adder tree; unused leaves of a
// non-power-of-two vector are padded with zero.
module vec_tree_sum #(
  parameter int IN_BITS = 8,
  parameter int VEC_LEN = 4
) (
  input  logic [IN_BITS*VEC_LEN-1:0]                 in_vec,
  output logic signed [IN_BITS+$clog2(VEC_LEN)-1:0]  sum_o
);

  localparam int LVL = $clog2(VEC_LEN);
  localparam int NP  = 1 << LVL;
  localparam int SW  = IN_BITS + LVL;

  logic signed [SW-1:0]      node [NP];
  logic signed [IN_BITS-1:0] lane;

  // Pairwise reduction in place: pass lv folds NP>>lv nodes down to NP>>(lv+1).
  always_comb begin
    lane = '0;
    for (int i = 0; i < NP; i++) begin
      if (i < VEC_LEN) begin
        lane    = in_vec[i*IN_BITS +: IN_BITS];
        node[i] = SW'(lane);
      end else begin
        node[i] = '0;
      end
    end
    for (int lv = 0; lv < LVL; lv++) begin
      for (int i = 0; i < NP / 2; i++) begin
        if (i < (NP >> (lv + 1))) begin
          node[i] = node[2*i] + node[2*i+1];
        end
      end
    end
    sum_o = node[0];
  end

endmodule

// File: rtl/vec_accum_stream.sv
// Streaming vector reducer: per-beat adder tree, wide packet accumulator,
// optional ReLU and saturation into a held output register.
`ifndef BITS
`define BITS 8
`endif
`ifndef VEC_LEN
`define VEC_LEN 4
`endif

module vec_accum_stream
  import qwac_pkg::*;
#(
  parameter int IN_BITS   = `BITS,
  parameter int OUT_BITS  = `BITS,
  parameter int VEC_LEN   = `VEC_LEN,
  parameter int ACC_BITS  = QWAC_ACC_BITS,
  parameter int MAX_BEATS = 255
) (
  input  logic                                clock,
  input  logic                                reset_n,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [IN_BITS*VEC_LEN-1:0]          in_vec,
  input  logic                                in_last,
  input  logic                                relu,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic signed [OUT_BITS-1:0]          out_sum,
  output logic                                out_sat,
  output logic [$clog2(MAX_BEATS+1)-1:0]      out_beats
);

  localparam int TW = IN_BITS + $clog2(VEC_LEN);
  localparam int CW = $clog2(MAX_BEATS + 1);

  logic                       adv;
  logic signed [TW-1:0]       tree_sum;

  logic                       s1_vld_q;
  logic signed [TW-1:0]       s1_sum_q;
  logic                       s1_last_q;
  logic                       first_q;
  logic                       relu_q;

  logic signed [ACC_BITS-1:0] acc_q;
  logic signed [ACC_BITS-1:0] acc_d;
  logic                       sat_q;
  logic [CW-1:0]              cnt_q;
  logic [CW-1:0]              cnt_d;

  logic                       out_valid_q;
  logic signed [OUT_BITS-1:0] out_sum_q;
  logic                       out_sat_q;
  logic [CW-1:0]              out_beats_q;

  logic signed [ACC_BITS:0]   sum_wide;
  logic signed [ACC_BITS-1:0] relu_v;
  sat_t                       acc_clip;
  sat_t                       out_clip;

  assign adv       = !out_valid_q || out_ready;
  assign in_ready  = adv;
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_sat   = out_sat_q;
  assign out_beats = out_beats_q;

  vec_tree_sum #(
    .IN_BITS (IN_BITS),
    .VEC_LEN (VEC_LEN)
  ) u_tree (
    .in_vec (in_vec),
    .sum_o  (tree_sum)
  );

  // One extra bit on the add so the ACC_BITS clip sees the true overflow.
  always_comb begin
    sum_wide = (ACC_BITS+1)'(acc_q) + (ACC_BITS+1)'(s1_sum_q);
    acc_clip = sat_clip(64'(sum_wide), ACC_BITS);
    acc_d    = acc_clip.val[ACC_BITS-1:0];
    relu_v   = (relu_q && acc_d[ACC_BITS-1]) ? '0 : acc_d;
    out_clip = sat_clip(64'(relu_v), OUT_BITS);
    cnt_d    = (cnt_q == CW'(MAX_BEATS)) ? cnt_q : cnt_q + CW'(1);
  end

  // Stage 1: tree sum capture (data path, no reset needed).
  always_ff @(posedge clock) begin
    if (adv && in_valid) begin
      s1_sum_q  <= tree_sum;
      s1_last_q <= in_last;
    end
  end

  // Stage 1 control, stage 2 accumulate and output register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_vld_q    <= 1'b0;
      first_q     <= 1'b1;
      relu_q      <= 1'b0;
      acc_q       <= '0;
      sat_q       <= 1'b0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_sat_q   <= 1'b0;
      out_beats_q <= '0;
    end else if (adv) begin
      s1_vld_q <= in_valid;
      if (in_valid) begin
        first_q <= in_last;
        if (first_q) relu_q <= relu;
      end
      if (s1_vld_q) begin
        if (s1_last_q) begin
          acc_q       <= '0;
          sat_q       <= 1'b0;
          cnt_q       <= '0;
          out_sum_q   <= OUT_BITS'(out_clip.val);
          out_sat_q   <= sat_q | acc_clip.clip | out_clip.clip;
          out_beats_q <= cnt_d;
        end else begin
          acc_q <= acc_d;
          sat_q <= sat_q | acc_clip.clip;
          cnt_q <= cnt_d;
        end
      end
      out_valid_q <= s1_vld_q && s1_last_q;
    end
  end

endmodule

// File: tb/tb_vec_accum_stream.sv
// Directed bench for vec_accum_stream with hand-computed expectations.
module tb_vec_accum_stream;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [31:0]       in_vec = '0;
  logic              in_last = 1'b0;
  logic              relu = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic signed [7:0] out_sum;
  logic              out_sat;
  logic [7:0]        out_beats;

  int checks = 0;
  int errors = 0;

  vec_accum_stream #(
    .IN_BITS   (8),
    .OUT_BITS  (8),
    .VEC_LEN   (4),
    .ACC_BITS  (16),
    .MAX_BEATS (255)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vec    (in_vec),
    .in_last   (in_last),
    .relu      (relu),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_sat   (out_sat),
    .out_beats (out_beats)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] v4(input int a, input int b, input int c, input int d);
    return {8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_res(input string tag, input int sum, input int sat, input int beats);
    chk({tag, "_valid"}, 32'(out_valid), 1);
    chk({tag, "_sum"}, 32'(out_sum), sum);
    chk({tag, "_sat"}, 32'(out_sat), sat);
    chk({tag, "_beats"}, 32'(out_beats), beats);
  endtask

  task automatic drive(input logic [31:0] v, input logic last, input logic r);
    in_valid = 1'b1;
    in_vec   = v;
    in_last  = last;
    relu     = r;
    @(posedge clock); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_sum", 32'(out_sum), 0);
    chk("rst_sat", 32'(out_sat), 0);
    chk("rst_beats", 32'(out_beats), 0);
    reset_n = 1'b1;
    @(posedge clock); #1;
    chk("rst_ready", 32'(in_ready), 1);

    // Single beat, latency of two edges
    drive(v4(1, 2, 3, 4), 1'b1, 1'b0);
    chk("lat_early", 32'(out_valid), 0);
    @(posedge clock); #1;
    chk_res("single", 10, 0, 1);
    consume();
    chk("single_gone", 32'(out_valid), 0);

    // Back-to-back multi-beat packet followed immediately by a new packet
    drive(v4(10, 10, 10, 10), 1'b0, 1'b0);
    drive(v4(10, 10, 10, 10), 1'b0, 1'b0);
    drive(v4(10, 10, 10, 10), 1'b1, 1'b0);
    drive(v4(-1, -1, -1, -1), 1'b1, 1'b0);
    chk_res("three", 120, 0, 3);
    chk("three_stall", 32'(in_ready), 0);
    @(posedge clock); #1;
    chk_res("three_hold", 120, 0, 3);
    consume();
    chk_res("neg4", -4, 0, 1);
    consume();
    chk("neg4_gone", 32'(out_valid), 0);

    // ReLU behaviour
    drive(v4(-5, -5, -5, -5), 1'b1, 1'b1);
    @(posedge clock); #1;
    chk_res("relu_on", 0, 0, 1);
    consume();
    drive(v4(-5, -5, -5, -5), 1'b1, 1'b0);
    @(posedge clock); #1;
    chk_res("relu_off", -20, 0, 1);
    consume();
    drive(v4(-5, -5, -5, -5), 1'b0, 1'b0);
    drive(v4(-5, -5, -5, -5), 1'b1, 1'b1);
    @(posedge clock); #1;
    chk_res("relu_late", -40, 0, 2);
    consume();

    // Saturation at both ends of the output range
    drive(v4(127, 127, 127, 127), 1'b0, 1'b0);
    drive(v4(127, 127, 127, 127), 1'b1, 1'b0);
    @(posedge clock); #1;
    chk_res("sat_pos", 127, 1, 2);
    consume();
    drive(v4(-128, -128, -128, -128), 1'b1, 1'b0);
    @(posedge clock); #1;
    chk_res("sat_neg", -128, 1, 1);
    consume();
    drive(v4(1, 1, 1, 1), 1'b1, 1'b0);
    @(posedge clock); #1;
    chk_res("sat_clear", 4, 0, 1);
    consume();

    // Backpressure: next packet waits while a result is held
    drive(v4(5, 5, 5, 5), 1'b1, 1'b0);
    @(posedge clock); #1;
    chk_res("bp_p1", 20, 0, 1);
    in_valid = 1'b1;
    in_vec   = v4(1, 1, 1, 1);
    in_last  = 1'b0;
    relu     = 1'b0;
    #1;
    chk("bp_ready0", 32'(in_ready), 0);
    @(posedge clock); #1;
    @(posedge clock); #1;
    chk("bp_ready1", 32'(in_ready), 0);
    chk_res("bp_hold", 20, 0, 1);
    out_ready = 1'b1;
    #1;
    chk("bp_ready_comb", 32'(in_ready), 1);
    @(posedge clock); #1;
    out_ready = 1'b0;
    chk("bp_p1_taken", 32'(out_valid), 0);
    in_vec  = v4(2, 2, 2, 2);
    in_last = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(posedge clock); #1;
    chk_res("bp_p2", 12, 0, 2);
    consume();

    // Reset in the middle of a packet discards the partial sum
    drive(v4(7, 7, 7, 7), 1'b0, 1'b0);
    drive(v4(7, 7, 7, 7), 1'b0, 1'b0);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_sum", 32'(out_sum), 0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;
    drive(v4(1, 1, 1, 1), 1'b1, 1'b0);
    @(posedge clock); #1;
    chk_res("post_rst", 4, 0, 1);
    consume();
    chk("post_rst_gone", 32'(out_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vec_accum_stream.md
# vec_accum_stream

Streaming successor to the combinational vector adder. It accepts VEC_LEN-lane signed vectors one beat per cycle over a valid/ready handshake and reduces each beat through a registered adder tree. Beats are summed into a wide accumulator until a beat marked last arrives. The finished packet then passes through optional ReLU and saturation to OUT_BITS, and the result is held in an output register until the consumer takes it. It feeds downstream neuron/activation stages where a dot-product row is longer than one vector.

## Interface
- IN_BITS, default `BITS: signed width of each input lane
- OUT_BITS, default `BITS: signed width of the result
- VEC_LEN, default `VEC_LEN: lanes per beat; must be ≥ 2
- ACC_BITS, default 32: signed accumulator width; must be ≥ IN_BITS+$clog2(VEC_LEN) and ≥ OUT_BITS
- MAX_BEATS, default 255: saturating limit of the beat counter

Ports:
- clock  in  1  sole clock; all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  beat present
- in_ready  out  1  beat accepted when in_valid && in_ready
- in_vec  in  IN_BITS x VEC_LEN  signed lanes
- in_last  in  1  final beat of packet
- relu  in  1  ReLU enable, sampled on the first beat of a packet
- out_valid  out  1  result held
- out_ready  in  1  result consumed when out_valid && out_ready
- out_sum  out  OUT_BITS  signed result
- out_sat  out  1  clipping occurred in this packet
- out_beats  out  $clog2(MAX_BEATS+1)  beats in packet, saturating at MAX_BEATS

## Operation
- Advance enable: adv = !out_valid || out_ready. in_ready = adv, combinationally.
- When adv is 0, no pipeline register updates.
- Stage 1 (on accept): register tree_sum, the sign-extended sum of all lanes at IN_BITS+$clog2(VEC_LEN) bits, together with the last flag. If this is the first beat of a packet, also latch relu.
- Stage 2 (s1 valid, adv):
  - next = acc + sext(tree_sum).
  - Saturate next to ACC_BITS signed range; set the sticky sat flag on clipping.
  - Increment the beat counter, saturating at MAX_BEATS.
- Stage 2, not last: acc ← next.
- Stage 2, last:
  - v = relu_latched && next<0 ? 0 : next.
  - out_sum ← v clipped to the OUT_BITS signed range.
  - out_sat ← sticky flag | (v clipped to OUT_BITS).
  - out_beats ← count.
  - out_valid ← 1.
  - acc, sticky flag and count ← 0, and the next beat starts a new packet.
- ReLU zeroing never sets out_sat.
- Consumption without a new result: out_valid ← 0; out_sum, out_sat and out_beats keep their values.
- Consumption with a new result arriving in the same edge: the output register loads the new result and out_valid stays 1.
- A single-beat packet (in_last on first beat) is legal.

## Timing
- Reset (reset_n low), asynchronous:
  - out_valid=0, out_sum=0, out_sat=0, out_beats=0.
  - acc, count, sticky flag and stage-1 valid cleared.
  - in_ready=1 once reset_n is high.
- Reset mid-packet discards the partial packet; the first beat after release starts a new packet.
- Latency: a last beat accepted at edge k gives out_valid high after edge k+1 (2 cycles).
- Throughput is one beat per cycle while out_ready=1 or no result is held.
- out_valid, out_sum, out_sat and out_beats are registered outputs.
- in_ready depends combinationally on out_ready.
- While out_valid && !out_ready, in_ready=0 and stage 1 holds. No data is lost or duplicated.
- out_* are stable while out_valid && !out_ready.

## Structure
- Shared package qwac_pkg holds:
  - the sat_clip function (value, target width): returns the clipped value and a flag
  - the default ACC_BITS constant
- `BITS and `VEC_LEN remain in constants.vh.
- Sub-module vec_tree_sum: combinational balanced signed adder tree, parametrised by IN_BITS and VEC_LEN, output IN_BITS+$clog2(VEC_LEN) bits. It handles non-power-of-two VEC_LEN by zero padding.
- The top level holds the handshake, the accumulator, the sequencing logic and the output register.

## Test plan
Bench configuration: IN_BITS=8, OUT_BITS=8, VEC_LEN=4, ACC_BITS=16.
- {1,2,3,4} with last, relu=0 → out_sum=10, out_sat=0, out_beats=1, out_valid 2 cycles after accept.
- Three beats of {10,10,10,10}, last on the third, back-to-back → out_sum=120, out_beats=3; then immediately {-1,-1,-1,-1} last → −4 on the next result.
- {-5,-5,-5,-5} last with relu=1 → out_sum=0, out_sat=0. Same beat with relu=0 → out_sum=−20. relu toggled on beat 2 of a 2-beat packet is ignored.
- Saturation:
  - Two beats of {127,127,127,127} → out_sum=127, out_sat=1.
  - {-128,-128,-128,-128} last → out_sum=−128, out_sat=1.
- Backpressure: hold out_ready=0 with a result pending while sending the next packet. in_ready must be 0 and stage 1 must hold. Release out_ready and both results must emerge in order with correct values.
- Drop reset_n after 2 of 4 beats, release, then send {1,1,1,1} last → out_sum=4, out_beats=1, with no stale contribution.
